alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the execute-stage 32-bit ALU.
- Accepts one operation per cycle through a valid/ready handshake and returns the result plus a full flag set (carry, zero, negative, overflow) one cycle later.
- Adds an iterative multi-cycle multiply that stalls the issue side while it runs.
- Sits in the EX stage between the ID/EX register and the EX/MEM register; the hazard unit consumes in_ready as a stall.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4.
- CW, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation presented on data1/data2/ctrl
- in_ready  out  1  block can accept an operation this cycle
- data1  in  WIDTH  operand A
- data2  in  WIDTH  operand B
- ctrl  in  3  operation select
- flush  in  1  synchronous abort of the in-flight operation (branch mispredict)
- out_valid  out  1  result/flags valid this cycle (single-cycle pulse per operation)
- out  out  WIDTH  result
- o_carry  out  1  carry / borrow / multiply-high-nonzero
- o_zero  out  1  out equals 0
- o_neg  out  1  out[WIDTH-1]
- o_ovf  out  1  signed overflow (add/sub only)

Behaviour:
- Reset (rst_n low, asynchronous): out, all flags, out_valid = 0; in_ready = 1; multiply state machine returns to IDLE with counter = 0. Reset asserted mid-multiply discards the operation; no out_valid is produced.
- Accept condition: in_valid && in_ready on a rising edge.
- ctrl encoding:
  - 010 ADD: {c,out} = A+B; ovf = (A[msb]==B[msb]) && (out[msb]!=A[msb]).
  - 110 SUB: {c,out} = A-B; c = borrow; ovf = (A[msb]!=B[msb]) && (out[msb]!=A[msb]).
  - 000 AND, 001 OR, 111 XOR: c = 0, ovf = 0.
  - 011 SLT: out = 1 if signed A<B, else 0; c = 0, ovf = 0.
  - 100 MUL: unsigned, low WIDTH bits to out; c = 1 if the high WIDTH bits are nonzero; ovf = 0.
  - 101 PASS: out = A; c = 0, ovf = 0.
- o_zero and o_neg are computed for every operation from the final out value.
- Single-cycle operations: result, flags and out_valid = 1 register on the accept edge, so they are visible in the following cycle. Back-to-back issue gives one result per cycle. Outputs hold their last value when out_valid = 0.
- MUL state machine:
  - IDLE: on MUL accept, load multiplicand, multiplier and a 2*WIDTH accumulator cleared to 0; go to BUSY; in_ready drops to 0 from the next cycle.
  - BUSY: one shift-add step per cycle for WIDTH cycles (counter counts 0..WIDTH-1).
  - DONE: on the edge ending the last step, register out and flags with out_valid = 1, return to IDLE, in_ready = 1.
  - Latency from accept to out_valid: WIDTH+1 cycles.
- flush:
  - In BUSY: go to IDLE on that edge, no out_valid, in_ready = 1 next cycle.
  - Coincident with a single-cycle accept: the operation is dropped (out_valid stays 0).
  - Otherwise: no effect.
- in_valid with in_ready = 0 is ignored; the source must hold the operation until it is accepted.

Optional Feature:
- ALU_MUL_EN defined: MUL is implemented as described above.
- ALU_MUL_EN undefined: ctrl 100 behaves as PASS (single cycle), in_ready is tied to 1, and the BUSY/DONE state machine and accumulator are not generated.

Test Plan:
- WIDTH=32, ADD A=0xFFFFFFFF, B=0x00000001 -> next cycle out=0, o_carry=1, o_zero=1, o_ovf=0, out_valid=1 for one cycle.
- ADD A=0x7FFFFFFF, B=1 -> out=0x80000000, o_ovf=1, o_neg=1, o_carry=0. SUB A=5, B=5 -> o_zero=1, o_carry=0. SLT A=0xFFFFFFFF, B=1 -> out=1.
- Back-to-back AND/OR/XOR on A=0xF0F0F0F0, B=0xFF00FF00 -> out 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0 on three consecutive cycles.
- ALU_MUL_EN, MUL A=0x00010000, B=0x00010000 -> in_ready low for 32 cycles; out=0, o_carry=1, o_zero=1 exactly 33 cycles after accept; an ADD held on in_valid during that window is accepted only afterwards.
- MUL A=7, B=6 with flush pulsed on cycle 10 -> no out_valid; in_ready=1 the cycle after the flush. Repeat with rst_n pulsed low mid-multiply -> all outputs 0 immediately (asynchronous).
- ALU_MUL_EN undefined, ctrl=100, A=0x1234 -> out=0x1234 one cycle later, in_ready never drops.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered EX-stage ALU with valid/ready issue and full flag set
// Optional iterative unsigned multiply on ctrl 100 is built only when ALU_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       ctrl,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  if (WIDTH < 4 || CW != $clog2(WIDTH) + 1) begin : g_bad_params
    $error("alu_pipe: WIDTH must be at least 4 and CW must keep its derived value");
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;
  logic             accept;
  logic             single_fire;

  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic             valid_q;

  assign accept = in_valid && in_ready;
  assign sum    = {1'b0, data1} + {1'b0, data2};
  assign diff   = {1'b0, data1} - {1'b0, data2};

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (ctrl)
      OP_AND:  res_d = data1 & data2;
      OP_OR:   res_d = data1 | data2;
      OP_XOR:  res_d = data1 ^ data2;
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (data1[MSB] == data2[MSB]) && (sum[MSB] != data1[MSB]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow out of the unsigned subtraction
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (data1[MSB] != data2[MSB]) && (diff[MSB] != data1[MSB]);
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_PASS: res_d = data1;
      default: res_d = data1;
    endcase
    zero_d = (res_d == '0);
    neg_d  = res_d[MSB];
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  assign in_ready    = (state_q == S_IDLE);
  assign single_fire = accept && !flush && (ctrl != OP_MUL);
  assign acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_step   = (cnt_q == CW'(WIDTH - 1));
`else
  assign in_ready    = 1'b1;
  assign single_fire = accept && !flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (single_fire) begin
        out_q   <= res_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
        neg_q   <= neg_d;
        ovf_q   <= ovf_d;
        valid_q <= 1'b1;
      end
`ifdef ALU_MUL_EN
      // in_ready is low while busy, so single_fire never overlaps a multiply step
      if (state_q == S_BUSY) begin
        if (flush) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= acc_step[WIDTH-1:0];
            carry_q <= |acc_step[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_step[WIDTH-1:0] == '0);
            neg_q   <= acc_step[MSB];
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
      end else if (accept && !flush && ctrl == OP_MUL) begin
        state_q  <= S_BUSY;
        cnt_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, data1};
        mplier_q <= data2;
        acc_q    <= '0;
      end
`endif
    end
  end

  assign out       = out_q;
  assign o_carry   = carry_q;
  assign o_zero    = zero_q;
  assign o_neg     = neg_q;
  assign o_ovf     = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe with a behavioural reference model
// Covers the multiply path when ALU_MUL_EN is defined, otherwise ctrl 100 as PASS.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ctrl;
  logic        flush;
  logic        out_valid;
  logic [31:0] out;
  logic        o_carry;
  logic        o_zero;
  logic        o_neg;
  logic        o_ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_r;
  logic        last_c, last_z, last_n, last_v;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .ctrl(ctrl), .flush(flush),
    .out_valid(out_valid), .out(out), .o_carry(o_carry), .o_zero(o_zero),
    .o_neg(o_neg), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Behavioural reference: plain arithmetic on wide integers.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic z,
                                output logic n, output logic v);
    logic [63:0] w;
    longint      s;
    r = a; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b111: r = a ^ b;
      3'b010: begin
        w = {32'h0, a} + {32'h0, b};
        r = w[31:0];
        c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > SMAX) || (s < SMIN);
      end
      3'b110: begin
        r = a - b;
        c = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > SMAX) || (s < SMIN);
      end
      3'b011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      3'b100: begin
        w = {32'h0, a} * {32'h0, b};
        r = w[31:0];
        c = (w[63:32] != 32'h0);
      end
`endif
      default: r = a;
    endcase
    z = (r == 32'h0);
    n = r[31];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_single_op();
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
`ifdef ALU_MUL_EN
    if (op == 3'b100) op = 3'b101;
`endif
    return op;
  endfunction

  // Issue one single-cycle operation; entered just after a clock edge with in_ready high.
  task automatic single_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string name);
    logic [31:0] er;
    logic ec, ez, en, ev;
    model(op, a, b, er, ec, ez, en, ev);
    in_valid = 1'b1; ctrl = op; data1 = a; data2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out, o_carry, o_zero, o_neg, o_ovf} !== {1'b1, er, ec, ez, en, ev}) begin
      errors++;
      $display("FAIL %s: op=%b a=%h b=%h got v=%b out=%h c=%b z=%b n=%b o=%b, expected v=1 out=%h c=%b z=%b n=%b o=%b",
               name, op, a, b, out_valid, out, o_carry, o_zero, o_neg, o_ovf, er, ec, ez, en, ev);
    end
    last_r = er; last_c = ec; last_z = ez; last_n = en; last_v = ev;
  endtask

  task automatic check_idle_hold(input string name);
    checks++;
    if ({out_valid, out, o_carry, o_zero, o_neg, o_ovf} !== {1'b0, last_r, last_c, last_z, last_n, last_v}) begin
      errors++;
      $display("FAIL %s: got v=%b out=%h c=%b z=%b n=%b o=%b, expected v=0 out=%h c=%b z=%b n=%b o=%b",
               name, out_valid, out, o_carry, o_zero, o_neg, o_ovf, last_r, last_c, last_z, last_n, last_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ctrl = 3'b000; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready} !== {1'b0, 32'h0, 4'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b out=%h flags=%b%b%b%b rdy=%b, expected v=0 out=0 flags=0000 rdy=1",
               out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready);
    end
    rst_n = 1'b1;
    last_r = '0; last_c = 0; last_z = 0; last_n = 0; last_v = 0;
    @(posedge clk); #1;
    check_idle_hold("reset_release_idle");
  endtask

  task automatic test_directed;
    single_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap_carry");
    @(posedge clk); #1;
    check_idle_hold("add_valid_single_pulse");
    single_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, "add_signed_ovf");
    single_op(3'b110, 32'd5, 32'd5, "sub_equal_zero");
    single_op(3'b110, 32'd3, 32'd5, "sub_borrow");
    single_op(3'b110, 32'h8000_0000, 32'd1, "sub_signed_ovf");
    single_op(3'b011, 32'hFFFF_FFFF, 32'd1, "slt_negative");
    single_op(3'b011, 32'd1, 32'hFFFF_FFFF, "slt_false");
    single_op(3'b101, 32'hCAFE_0001, 32'h1234_5678, "pass_a");
  endtask

  task automatic test_back_to_back;
    single_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, "b2b_and");
    single_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, "b2b_or");
    single_op(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, "b2b_xor");
    for (int i = 0; i < 60; i++)
      single_op(rand_single_op(), rand_operand(), rand_operand(), "b2b_random");
    @(posedge clk); #1;
    check_idle_hold("b2b_tail_hold");
  endtask

  task automatic test_flush_single;
    single_op(3'b101, 32'h0BAD_F00D, 32'h0, "pre_flush_pass");
    in_valid = 1'b1; flush = 1'b1; ctrl = 3'b010; data1 = 32'd1; data2 = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_idle_hold("flush_drops_single");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle_hold("flush_idle_no_effect");
    single_op(3'b110, 32'd10, 32'd4, "post_flush_sub");
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] er, ar, br;
    logic ec, ez, en, ev;
    int n, lowcnt;
    model(3'b100, a, b, er, ec, ez, en, ev);
    in_valid = 1'b1; ctrl = 3'b100; data1 = a; data2 = b;
    @(posedge clk); #1;
    ar = $urandom; br = $urandom;
    ctrl = 3'b010; data1 = ar; data2 = br;
    n = 0; lowcnt = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready === 1'b0) lowcnt++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n + 1 != 33 || lowcnt != 32) begin
      errors++;
      $display("FAIL %s_latency: got latency=%0d ready_low=%0d, expected latency=33 ready_low=32", name, n + 1, lowcnt);
    end
    checks++;
    if ({out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready} !== {1'b1, er, ec, ez, en, ev, 1'b1}) begin
      errors++;
      $display("FAIL %s_result: a=%h b=%h got v=%b out=%h c=%b z=%b n=%b o=%b rdy=%b, expected v=1 out=%h c=%b z=%b n=%b o=0 rdy=1",
               name, a, b, out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready, er, ec, ez, en);
    end
    single_op(3'b010, ar, br, {name, "_held_add"});
  endtask

  task automatic test_mul;
    mul_op(32'h0001_0000, 32'h0001_0000, "mul_high_only");
    mul_op(32'd7, 32'd6, "mul_small");
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    for (int i = 0; i < 4; i++)
      mul_op($urandom, $urandom, "mul_random");
    @(posedge clk); #1;
    check_idle_hold("mul_tail_hold");
  endtask

  task automatic test_mul_flush;
    int extra_valid;
    single_op(3'b101, 32'h0000_1111, 32'h0, "pre_mul_flush");
    in_valid = 1'b1; ctrl = 3'b100; data1 = 32'd7; data2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_flush_abort: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
    end
    extra_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) extra_valid++;
    end
    checks++;
    if (extra_valid != 0) begin
      errors++;
      $display("FAIL mul_flush_no_result: got %0d valid pulses, expected 0", extra_valid);
    end
    check_idle_hold("mul_flush_hold");
  endtask

  task automatic test_mul_reset;
    int extra_valid;
    single_op(3'b101, 32'hDEAD_BEEF, 32'h0, "pre_mul_reset");
    in_valid = 1'b1; ctrl = 3'b100; data1 = 32'd7; data2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready} !== {1'b0, 32'h0, 4'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_async_reset: got v=%b out=%h flags=%b%b%b%b rdy=%b, expected v=0 out=0 flags=0000 rdy=1",
               out_valid, out, o_carry, o_zero, o_neg, o_ovf, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) extra_valid++;
    end
    checks++;
    if (extra_valid != 0) begin
      errors++;
      $display("FAIL mul_reset_discard: got %0d bad cycles, expected 0", extra_valid);
    end
    single_op(3'b010, 32'd100, 32'd23, "post_reset_add");
  endtask
`else
  task automatic test_pass_no_stall;
    int stalls;
    stalls = 0;
    single_op(3'b100, 32'h0000_1234, 32'h5555_AAAA, "op100_as_pass");
    for (int i = 0; i < 20; i++) begin
      if (in_ready !== 1'b1) stalls++;
      single_op((i % 2 == 0) ? 3'b100 : rand_single_op(), rand_operand(), rand_operand(), "op100_stream");
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL op100_never_stalls: got %0d cycles with in_ready low, expected 0", stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_single();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`else
    test_pass_no_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
